noun_readout: RTL and testbench
===============================

// Module: noun_readout
// PURPOSE
//  Reader end of the NockPU memory-request protocol: after mem_traversal reports finished, walks a
//  contiguous window of memory_unit words and streams them out over a valid/ready word port.
//  Used to return reduced nouns to a host/bench.
//  Sits as an extra initiator leg on memory_mux; it only issues reads.
// PARAMETERS
//  ADDR_W       `memory_addr_width   address width, matches memory_unit
//  DATA_W       `memory_data_width   word width, matches memory_unit
//  FUNC_READ    2'b00                mem_func code driven for a read
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse; latch base_addr/word_count, begin readout
//  base_addr    in   ADDR_W  first word address
//  word_count   in   ADDR_W  number of words to stream
//  busy         out  1       high from accepted start until finished
//  finished     out  1       1-cycle pulse after last beat (and checksum) accepted
//  mem_ready    in   1       memory_unit is_ready
//  mem_execute  out  1       memory request strobe
//  mem_func     out  2       always FUNC_READ while mem_execute is high
//  address1     out  ADDR_W  read address
//  read_data1   in   DATA_W  memory read port 1
//  out_data     out  DATA_W  stream word
//  out_valid    out  1       stream word valid
//  out_last     out  1       marks final beat of the readout
//  out_ready    in   1       downstream accepts when valid&ready
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Active-low reset asserted mid-op aborts immediately; no finished.
//  States: IDLE -> REQ -> ACK -> DATA -> SEND -> (REQ | CSUM | DONE) -> IDLE.
//  IDLE: start with word_count==0 -> DONE directly (no beats, except checksum, see CONFIG);
//        start otherwise -> latch addr=base_addr, remaining=word_count, busy=1, -> REQ.
//        start while busy is ignored.
//  REQ: wait mem_ready=1; then mem_execute=1, mem_func=FUNC_READ, address1=addr -> ACK.
//  ACK: hold mem_execute/address1 until mem_ready seen 0 (request accepted); drop mem_execute -> DATA.
//  DATA: on first cycle mem_ready=1 capture read_data1 into out_data -> SEND.
//  SEND: out_valid=1, out_last=(remaining==1 && no checksum). Hold data stable until out_ready.
//        On handshake: addr<=addr+1 (mod 2^ADDR_W, wraps 'hFF..F->0), remaining<=remaining-1;
//        remaining was 1 -> CSUM (if enabled) else DONE; else -> REQ.
//  DONE: finished=1 for exactly one cycle, busy=0 same cycle -> IDLE.
//  One outstanding memory request max; no prefetch. Min latency/word: 4 cycles + memory latency
//  + stall; out_valid never deasserts without a handshake.
//  mem_execute low in IDLE/DATA/SEND/DONE so other mux legs are unaffected when deselected.
//  Address wrap is silent; word_count counts beats, not address span.
// CONFIGURATION
//  READOUT_CHECKSUM_EN defined: CSUM state appends one extra beat, out_data = XOR of all streamed
//   words (0 when word_count==0), out_last=1 on that beat only; data beats never carry out_last.
//  Undefined: no CSUM state; last data beat carries out_last; word_count==0 emits nothing.
// TESTING
//  1 base=1,count=3, mem[1..3]=A,B,C, out_ready=1 -> beats A,B,C, out_last on C, one finished pulse.
//  2 same as 1 with out_ready low 5 cycles on beat B -> out_data=B and out_valid held stable, no
//    new mem_execute until B accepted.
//  3 count=0 -> finished 1 cycle after start, no out_valid (CHECKSUM_EN: single beat 0, last=1).
//  4 base='hFF..F, count=2 -> addresses 'hFF..F then 0 on address1.
//  5 rst low during SEND of beat 2 of 4 -> all outputs 0 next edge, restart start re-reads from base.
//  6 CHECKSUM_EN, mem=5,3 count=2 -> beats 5,3,6; out_last only on 6; second start while busy ignored.

Source files
------------

// File: rtl/noun_readout.sv
// +--------------------------------------------------------------------------+
// | noun_readout: streams a window of memory words out over valid/ready.     |
// | Optional: READOUT_CHECKSUM_EN appends an XOR checksum beat. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module noun_readout #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 16,
  parameter logic [1:0]  FUNC_READ = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              finished,
  input  logic              mem_ready,
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address1,
  input  logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACK  = 3'd2,
    S_DATA = 3'd3,
    S_SEND = 3'd4,
`ifdef READOUT_CHECKSUM_EN
    S_CSUM = 3'd5,
`endif
    S_DONE = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
`ifdef READOUT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
`ifdef READOUT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
`ifdef READOUT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    busy        = 1'b0;
    finished    = 1'b0;
    mem_execute = 1'b0;
    mem_func    = 2'b00;
    address1    = '0;
    out_data    = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = word_count;
`ifdef READOUT_CHECKSUM_EN
          csum_d      = '0;
          state_d     = (word_count == '0) ? S_CSUM : S_REQ;
`else
          state_d     = (word_count == '0) ? S_DONE : S_REQ;
`endif
        end
      end
      S_REQ: begin
        busy = 1'b1;
        if (mem_ready) state_d = S_ACK;
      end
      // Request stays asserted until the memory drops ready to take it.
      S_ACK: begin
        busy        = 1'b1;
        mem_execute = 1'b1;
        mem_func    = FUNC_READ;
        address1    = addr_q;
        if (!mem_ready) state_d = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (mem_ready) begin
          data_d  = read_data1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = data_q;
`ifndef READOUT_CHECKSUM_EN
        out_last  = (remaining_q == ONE);
`endif
        if (out_ready) begin
          addr_d      = addr_q + ONE;
          remaining_d = remaining_q - ONE;
`ifdef READOUT_CHECKSUM_EN
          csum_d      = csum_q ^ data_q;
          state_d     = (remaining_q == ONE) ? S_CSUM : S_REQ;
`else
          state_d     = (remaining_q == ONE) ? S_DONE : S_REQ;
`endif
        end
      end
`ifdef READOUT_CHECKSUM_EN
      S_CSUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = csum_q;
        out_last  = 1'b1;
        if (out_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        finished = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_noun_readout.sv
// Scoreboard bench for noun_readout: directed reads against a handshaking memory model.
`default_nettype none
`timescale 1ns/1ps

module tb_noun_readout;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] word_count = '0;
  logic          busy, finished, mem_ready, mem_execute;
  logic [1:0]    mem_func;
  logic [AW-1:0] address1;
  logic [DW-1:0] read_data1, out_data;
  logic          out_valid, out_last, out_ready;

  always #5 clk = ~clk;

  noun_readout #(.ADDR_W(AW), .DATA_W(DW), .FUNC_READ(2'b00)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .finished(finished), .mem_ready(mem_ready), .mem_execute(mem_execute),
    .mem_func(mem_func), .address1(address1), .read_data1(read_data1),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem [0:255];
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_log[$];
  int fin_cnt = 0;
  int hs_cnt = 0;
  int stall_beat = -1;
  int stall_left = 0;
  int exec_overlap = 0;
  int lat = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Memory model: takes a request by dropping ready, returns data after lat cycles.
  initial begin
    logic [AW-1:0] a;
    mem_ready  = 1'b1;
    read_data1 = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ready = 1'b1;
      end else if (mem_execute && mem_ready) begin
        a = address1;
        addr_log.push_back(a);
        check("mem_func", 32'(mem_func), 32'd0);
        mem_ready = 1'b0;
        repeat (lat) @(negedge clk);
        read_data1 = mem[a];
        mem_ready  = 1'b1;
      end
    end
  end

  // Ready driver plus scoreboard monitor.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW:0]   e;
    prev_stall = 1'b0;
    prev_data  = '0;
    out_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
        out_ready  = 1'b1;
      end else begin
        if (out_valid && hs_cnt == stall_beat && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && mem_execute) exec_overlap++;
        if (finished) begin
          fin_cnt++;
          check("busy_at_finish", 32'(busy), 32'd0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data %0h last %0b, required no beat", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(out_data), 32'(e[DW-1:0]));
            check("beat_last", 32'(out_last), 32'(e[DW]));
          end
          hs_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic expect_read(input logic [AW-1:0] b, input int n);
    logic [DW-1:0] cs;
    logic [AW-1:0] a;
    cs = '0;
    a  = b;
    for (int i = 0; i < n; i++) begin
`ifdef READOUT_CHECKSUM_EN
      exp_q.push_back({1'b0, mem[a]});
`else
      exp_q.push_back({(i == n - 1), mem[a]});
`endif
      cs = cs ^ mem[a];
      a  = a + 1'b1;
    end
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back({1'b1, cs});
`endif
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    @(negedge clk);
    hs_cnt     = 0;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_finish(input int target, input string name);
    int n;
    n = 0;
    while (fin_cnt < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(fin_cnt), 32'(target));
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_finished"}, 32'(finished), 32'd0);
    check({name, "_mem_execute"}, 32'(mem_execute), 32'd0);
    check({name, "_address1"}, 32'(address1), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_last"}, 32'(out_last), 32'd0);
    check({name, "_out_data"}, 32'(out_data), 32'd0);
  endtask

  initial begin
    int f0;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 16'h0100);

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // 1: three beats A,B,C from base 1
    mem[1] = 16'h00A1; mem[2] = 16'h00B2; mem[3] = 16'h00C3;
    f0 = fin_cnt;
    expect_read(8'h01, 3);
    pulse_start(8'h01, 8'd3);
    wait_finish(f0 + 1, "t1_finished");
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_one_pulse", 32'(fin_cnt), 32'(f0 + 1));

    // 2: stall beat B for 5 cycles
    f0 = fin_cnt;
    exec_overlap = 0;
    stall_beat = 1;
    stall_left = 5;
    expect_read(8'h01, 3);
    pulse_start(8'h01, 8'd3);
    wait_finish(f0 + 1, "t2_finished");
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);
    check("t2_no_exec_while_valid", 32'(exec_overlap), 32'd0);
    check("t2_stall_used", 32'(stall_left), 32'd0);
    stall_beat = -1;

    // 3: zero-length readout
    f0 = fin_cnt;
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back({1'b1, 16'h0000});
    pulse_start(8'h20, 8'd0);
    wait_finish(f0 + 1, "t3_finished");
`else
    pulse_start(8'h20, 8'd0);
    check("t3_finished_now", 32'(finished), 32'd1);
    check("t3_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t3_finished_drops", 32'(finished), 32'd0);
`endif
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: address wrap
    mem[8'hFF] = 16'h1111; mem[8'h00] = 16'h2222;
    addr_log.delete();
    f0 = fin_cnt;
    expect_read(8'hFF, 2);
    pulse_start(8'hFF, 8'd2);
    wait_finish(f0 + 1, "t4_finished");
    check("t4_n_addr", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("t4_addr0", 32'(addr_log[0]), 32'h0FF);
      check("t4_addr1", 32'(addr_log[1]), 32'h000);
    end

    // 5: reset during SEND of beat 2 of 4, then restart
    f0 = fin_cnt;
    stall_beat = 1;
    stall_left = 100;
    exp_q.push_back({1'b0, mem[8'h10]});
    pulse_start(8'h10, 8'd4);
    n = 0;
    while (!(hs_cnt == 1 && out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("t5_reached_beat2", 32'(hs_cnt == 1 && out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("t5_abort");
    stall_left = 0;
    stall_beat = -1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("t5_no_finish", 32'(fin_cnt), 32'(f0));
    rst = 1'b1;
    addr_log.delete();
    expect_read(8'h10, 4);
    pulse_start(8'h10, 8'd4);
    wait_finish(f0 + 1, "t5_finished");
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    if (addr_log.size() > 0) check("t5_reread_base", 32'(addr_log[0]), 32'h010);
    else check("t5_reread_base", 32'hFFFF_FFFF, 32'h010);

    // 6: data 5,3 (checksum 6); second start while busy ignored
    mem[8'h40] = 16'h0005; mem[8'h41] = 16'h0003;
    addr_log.delete();
    f0 = fin_cnt;
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b1, 16'h0006});
`else
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b1, 16'h0003});
`endif
    pulse_start(8'h40, 8'd2);
    repeat (2) @(negedge clk);
    check("t6_busy", 32'(busy), 32'd1);
    base_addr  = 8'h80;
    word_count = 8'd5;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    wait_finish(f0 + 1, "t6_finished");
    repeat (30) @(negedge clk);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    check("t6_single_finish", 32'(fin_cnt), 32'(f0 + 1));
    check("t6_n_addr", 32'(addr_log.size()), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
